bsg_manycore_accel_driver: RTL

// Initiator for the three-register accelerator forwarding protocol. Word 0 holds the forward

---
 rtl/bsg_manycore_accel_driver_if.sv | 53 +++++
 rtl/bsg_manycore_accel_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_accel_driver_if.sv
// Signal bundle of the accelerator forwarding driver: command, payload stream,
// outgoing store packets and returned credits.
interface bsg_manycore_accel_driver_if #(
    parameter int unsigned x_cord_width_p    = 7,
    parameter int unsigned y_cord_width_p    = 7,
    parameter int unsigned addr_width_p      = 28,
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned max_out_credits_p = 16,
    parameter int unsigned len_width_p       = 16
);
    localparam int unsigned credit_width_lp = $clog2(max_out_credits_p + 1);

    logic                       cmd_v_i;
    logic                       cmd_ready_o;
    logic [x_cord_width_p-1:0]  cmd_accel_x_i;
    logic [y_cord_width_p-1:0]  cmd_accel_y_i;
    logic [addr_width_p-1:0]    cmd_fwd_addr_i;
    logic [x_cord_width_p-1:0]  cmd_fwd_x_i;
    logic [y_cord_width_p-1:0]  cmd_fwd_y_i;
    logic [len_width_p-1:0]     cmd_len_i;

    logic                       data_v_i;
    logic [data_width_p-1:0]    data_i;
    logic                       data_yumi_o;

    logic                       out_v_o;
    logic                       out_ready_i;
    logic [addr_width_p-1:0]    out_addr_o;
    logic [data_width_p-1:0]    out_data_o;
    logic [x_cord_width_p-1:0]  out_x_cord_o;
    logic [y_cord_width_p-1:0]  out_y_cord_o;

    logic                       credit_v_i;
    logic                       busy_o;
    logic                       done_o;
    logic [credit_width_lp-1:0] credits_o;

    modport master (
        input  cmd_v_i, cmd_accel_x_i, cmd_accel_y_i, cmd_fwd_addr_i,
               cmd_fwd_x_i, cmd_fwd_y_i, cmd_len_i,
               data_v_i, data_i, out_ready_i, credit_v_i,
        output cmd_ready_o, data_yumi_o, out_v_o, out_addr_o, out_data_o,
               out_x_cord_o, out_y_cord_o, busy_o, done_o, credits_o
    );

    modport slave (
        output cmd_v_i, cmd_accel_x_i, cmd_accel_y_i, cmd_fwd_addr_i,
               cmd_fwd_x_i, cmd_fwd_y_i, cmd_len_i,
               data_v_i, data_i, out_ready_i, credit_v_i,
        input  cmd_ready_o, data_yumi_o, out_v_o, out_addr_o, out_data_o,
               out_x_cord_o, out_y_cord_o, busy_o, done_o, credits_o
    );
endinterface

// File: rtl/bsg_manycore_accel_driver.sv
// Programs a forwarding accelerator (addr word, dest word) then streams N payload
// words to its forward register; credit-limited, done only after all stores are acked.
module bsg_manycore_accel_driver #(
    parameter int unsigned x_cord_width_p    = 7,
    parameter int unsigned y_cord_width_p    = 7,
    parameter int unsigned addr_width_p      = 28,
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned max_out_credits_p = 16,
    parameter int unsigned len_width_p       = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bsg_manycore_accel_driver_if.master bus
);
    localparam int unsigned credit_width_lp = $clog2(max_out_credits_p + 1);
    localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(max_out_credits_p);

    typedef enum logic [2:0] {
        IDLE,
        SEND_ADDR,
        SEND_DEST,
        SEND_DATA,
        DRAIN,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic [len_width_p-1:0]     remaining_q, remaining_d;
    logic [x_cord_width_p-1:0]  accel_x_q, accel_x_d;
    logic [y_cord_width_p-1:0]  accel_y_q, accel_y_d;
    logic [addr_width_p-1:0]    fwd_addr_q, fwd_addr_d;
    logic [x_cord_width_p-1:0]  fwd_x_q, fwd_x_d;
    logic [y_cord_width_p-1:0]  fwd_y_q, fwd_y_d;

    logic                       out_v_c;
    logic [addr_width_p-1:0]    out_addr_c;
    logic [data_width_p-1:0]    out_data_c;
    logic                       cmd_ready_c;
    logic                       data_yumi_c;
    logic                       fire_c;
    logic                       have_credit_c;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            credits_q   <= credits_max_lp;
            remaining_q <= '0;
            accel_x_q   <= '0;
            accel_y_q   <= '0;
            fwd_addr_q  <= '0;
            fwd_x_q     <= '0;
            fwd_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            remaining_q <= remaining_d;
            accel_x_q   <= accel_x_d;
            accel_y_q   <= accel_y_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_x_q     <= fwd_x_d;
            fwd_y_q     <= fwd_y_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credits_d     = credits_q;
        remaining_d   = remaining_q;
        accel_x_d     = accel_x_q;
        accel_y_d     = accel_y_q;
        fwd_addr_d    = fwd_addr_q;
        fwd_x_d       = fwd_x_q;
        fwd_y_d       = fwd_y_q;
        out_v_c       = 1'b0;
        out_addr_c    = '0;
        out_data_c    = '0;
        cmd_ready_c   = 1'b0;
        data_yumi_c   = 1'b0;
        have_credit_c = (credits_q != '0);

        // Packet presentation; valid is a function of registered state and payload valid only
        case (state_q)
            SEND_ADDR: begin
                out_v_c    = have_credit_c;
                out_addr_c = addr_width_p'(0);
                out_data_c = data_width_p'(fwd_addr_q);
            end
            SEND_DEST: begin
                out_v_c    = have_credit_c;
                out_addr_c = addr_width_p'(1);
                out_data_c = data_width_p'({fwd_y_q, fwd_x_q});
            end
            SEND_DATA: begin
                out_v_c    = bus.data_v_i & have_credit_c;
                out_addr_c = addr_width_p'(2);
                out_data_c = bus.data_i;
            end
            default: ;
        endcase

        fire_c      = out_v_c & bus.out_ready_i;
        data_yumi_c = fire_c && (state_q == SEND_DATA);

        // Simultaneous issue and return cancel out
        if (fire_c && !bus.credit_v_i) begin
            credits_d = credits_q - credit_width_lp'(1);
        end else if (!fire_c && bus.credit_v_i && (credits_q != credits_max_lp)) begin
            credits_d = credits_q + credit_width_lp'(1);
        end

        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_v_i) begin
                    accel_x_d   = bus.cmd_accel_x_i;
                    accel_y_d   = bus.cmd_accel_y_i;
                    fwd_addr_d  = bus.cmd_fwd_addr_i;
                    fwd_x_d     = bus.cmd_fwd_x_i;
                    fwd_y_d     = bus.cmd_fwd_y_i;
                    remaining_d = bus.cmd_len_i;
                    state_d     = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                if (fire_c) state_d = SEND_DEST;
            end
            SEND_DEST: begin
                if (fire_c) state_d = (remaining_q != '0) ? SEND_DATA : DRAIN;
            end
            SEND_DATA: begin
                if (fire_c) begin
                    remaining_d = remaining_q - len_width_p'(1);
                    if (remaining_q == len_width_p'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Store fence: leave as soon as the final credit lands
                if (credits_d == credits_max_lp) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready_o  = cmd_ready_c;
    assign bus.data_yumi_o  = data_yumi_c;
    assign bus.out_v_o      = out_v_c;
    assign bus.out_addr_o   = out_addr_c;
    assign bus.out_data_o   = out_data_c;
    assign bus.out_x_cord_o = (state_q == IDLE) ? '0 : accel_x_q;
    assign bus.out_y_cord_o = (state_q == IDLE) ? '0 : accel_y_q;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.done_o       = (state_q == DONE);
    assign bus.credits_o    = credits_q;

    credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(bus.credit_v_i && (credits_q == credits_max_lp)))
        else $error("credit returned while credit counter is full");

endmodule
